// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default widths for the single-port SRAM arbiter
//
// Holds the arbiter FSM state type and the default parameter values used by
// sram_1rw_arbiter. No ports.

package sram_arb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_READ_LAT   = 1;
   localparam int STAT_WIDTH     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with last-grant memory
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req[1:0]     request per port
//   accept       grant was taken this cycle; commits gnt into last_grant
//   gnt[1:0]     one-hot grant (zero when nothing is requested)

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // Port that won the most recent accepted grant; 1 after reset so port 0 wins first.
   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Only a taken grant moves the pointer, so a request withdrawn before
   // acceptance leaves the rotation untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// rtl/sram_1rw_arbiter.sv - two-port round-robin front end for a single-port 1RW SRAM
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   pN_valid/pN_ready             request handshake (N = 0, 1); ready only in IDLE for the granted port
//   pN_we, pN_addr, pN_wdata      request type (1 = write), address, write data
//   pN_rvalid, pN_rdata           one-cycle read-return pulse and held read data
//   sram_csb/web/oeb              active-low SRAM chip select, write enable, output enable
//   sram_addr, sram_dout          SRAM address and write data
//   sram_dout_en                  enable for the top-level tristate driver of the data bus
//   sram_din                      data read back from the bus
//   p0_grant_cnt, p1_grant_cnt    saturating acceptance counters, present only with SRAM_ARB_STATS_EN

module sram_1rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int READ_LAT   = DEF_READ_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_valid,
   output logic                  p0_ready,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_valid,
   output logic                  p1_ready,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic                  sram_oeb,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_dout,
   output logic                  sram_dout_en,
`ifdef SRAM_ARB_STATS_EN
   output logic [STAT_WIDTH-1:0] p0_grant_cnt,
   output logic [STAT_WIDTH-1:0] p1_grant_cnt,
`endif
   input  logic [DATA_WIDTH-1:0] sram_din
);

   localparam logic [1:0] RD_LAST = 2'(READ_LAT - 1);

   arb_state_t state;
   logic       we_q;
   logic       owner_q;
   logic [1:0] rd_cnt;

   logic [1:0] gnt;
   logic [1:0] ready;
   logic       accept;
   logic       sel;

   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst    (rst),
      .req    ({p1_valid, p0_valid}),
      .accept (accept),
      .gnt    (gnt)
   );

   // gnt is a subset of the valids, so any ready bit is an acceptance.
   assign ready    = (state == IDLE) ? gnt : 2'b00;
   assign p0_ready = ready[0];
   assign p1_ready = ready[1];
   assign accept   = |ready;
   assign sel      = ready[1];

   assign req_we    = sel ? p1_we    : p0_we;
   assign req_addr  = sel ? p1_addr  : p0_addr;
   assign req_wdata = sel ? p1_wdata : p0_wdata;

   // SRAM controls are registered and set up one edge ahead of the state they
   // belong to. sram_addr and sram_dout double as the latched request address
   // and write data; both stay stable through the whole transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         owner_q      <= 1'b0;
         rd_cnt       <= 2'd0;
         sram_csb     <= 1'b1;
         sram_web     <= 1'b1;
         sram_oeb     <= 1'b1;
         sram_dout_en <= 1'b0;
         sram_addr    <= '0;
         sram_dout    <= '0;
         p0_rvalid    <= 1'b0;
         p1_rvalid    <= 1'b0;
         p0_rdata     <= '0;
         p1_rdata     <= '0;
      end else begin
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state        <= ACCESS;
                  we_q         <= req_we;
                  owner_q      <= sel;
                  sram_csb     <= 1'b0;
                  sram_addr    <= req_addr;
                  sram_web     <= ~req_we;
                  sram_oeb     <= req_we;
                  sram_dout_en <= req_we;
                  if (req_we) begin
                     sram_dout <= req_wdata;
                  end
               end
            end
            ACCESS: begin
               sram_csb     <= 1'b1;
               sram_web     <= 1'b1;
               sram_dout_en <= 1'b0;
               rd_cnt       <= 2'd0;
               if (we_q) begin
                  state    <= IDLE;
                  sram_oeb <= 1'b1;
               end else begin
                  state    <= RDWAIT;
                  sram_oeb <= 1'b0;
               end
            end
            RDWAIT: begin
               if (rd_cnt == RD_LAST) begin
                  state    <= IDLE;
                  sram_oeb <= 1'b1;
                  if (owner_q) begin
                     p1_rdata  <= sram_din;
                     p1_rvalid <= 1'b1;
                  end else begin
                     p0_rdata  <= sram_din;
                     p0_rvalid <= 1'b1;
                  end
               end else begin
                  rd_cnt <= rd_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SRAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         p0_grant_cnt <= '0;
         p1_grant_cnt <= '0;
      end else begin
         if (ready[0] && (p0_grant_cnt != '1)) begin
            p0_grant_cnt <= p0_grant_cnt + 1'b1;
         end
         if (ready[1] && (p1_grant_cnt != '1)) begin
            p1_grant_cnt <= p1_grant_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/sram_1rw_arbiter.md
SRAM_1RW_ARBITER -- requirements
Module: sram_1rw_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width (256 words).
REQ-003 SHALL have parameter READ_LAT, default 1, range 1-4, clock edges from SRAM read edge to data capture.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports pN_valid / pN_ready  input / output  1  request handshake, for N = 0, 1.
REQ-007 SHALL have port pN_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports pN_addr  input  ADDR_WIDTH  and pN_wdata  input  DATA_WIDTH.
REQ-009 SHALL have ports pN_rvalid  output  1  and pN_rdata  output  DATA_WIDTH  read return.
REQ-010 SHALL have ports sram_csb, sram_web, sram_oeb  output  1  active-low SRAM controls.
REQ-011 SHALL have ports sram_addr  output  ADDR_WIDTH  and sram_dout  output  DATA_WIDTH  write data.
REQ-012 SHALL have port sram_dout_en  output  1  tristate enable for the bidirectional data bus (bus driven at top level).
REQ-013 SHALL have port sram_din  input  DATA_WIDTH  data read back from the bus.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RDWAIT.
REQ-015 SHALL assert pN_ready combinationally only in IDLE, and only for the granted port; a request is accepted when pN_valid && pN_ready.
REQ-016 SHALL arbitrate round-robin: with one port valid, that port is granted; with both valid, the port not granted last.
REQ-017 SHALL update last_grant only on acceptance.
REQ-018 SHALL register addr, we and wdata on acceptance and move IDLE -> ACCESS.
REQ-019 ACCESS, 1 cycle: sram_csb=0, sram_addr=latched addr, control per transfer type:
  - write: sram_web=0, sram_oeb=1, sram_dout_en=1, sram_dout=wdata; next state IDLE.
  - read: sram_web=1, sram_oeb=0, sram_dout_en=0; next state RDWAIT.
REQ-020 RDWAIT SHALL last READ_LAT cycles with sram_csb=1, sram_web=1, sram_oeb=0 and sram_dout_en=0.
REQ-021 On the final RDWAIT edge, SHALL capture sram_din into the owner's pN_rdata, pulse that pN_rvalid for exactly one cycle and return to IDLE.
REQ-022 Read latency SHALL be: accept in cycle N -> pN_rvalid high in cycle N+2+READ_LAT.
REQ-023 Write throughput SHALL be one accepted request per 2 cycles; read throughput one per 2+READ_LAT cycles.
REQ-024 pN_rdata SHALL hold its last value until the next read returns to that port; the other port's rdata/rvalid SHALL be unaffected.
REQ-025 Outside ACCESS/RDWAIT, SHALL drive sram_csb=1, sram_web=1, sram_oeb=1, sram_dout_en=0.
REQ-026 sram_web=0 and sram_dout_en=0 SHALL never occur together; sram_dout_en=1 and sram_oeb=0 SHALL never occur together.
REQ-027 A valid dropped before acceptance SHALL be ignored without state change.

Reset
REQ-028 rst SHALL force IDLE, last_grant=1 (port 0 wins first), all SRAM controls inactive, pN_rvalid=0, pN_rdata=0.
REQ-029 rst during ACCESS or RDWAIT SHALL abort the transfer; no pN_rvalid SHALL follow.

Configuration
REQ-030 With SRAM_ARB_STATS_EN defined, SHALL add outputs p0_grant_cnt and p1_grant_cnt, 16 bits each, incremented on acceptance, saturating at 0xFFFF and cleared by rst.
REQ-031 Without SRAM_ARB_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-032 Package sram_arb_pkg SHALL hold the FSM state enum and the default width constants.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arb2 (two requests, last-grant state).

Verification
REQ-034 p0 write addr 0x10 data 0xDEADBEEF -> ACCESS cycle with csb=0, web=0, dout_en=1, sram_addr=0x10; back in IDLE the next cycle.
REQ-035 Write 0xDEADBEEF to 0x10, then p1 read 0x10 accepted in cycle N -> p1_rvalid high in cycle N+3 with p1_rdata=0xDEADBEEF; p0_rvalid stays 0.
REQ-036 Both ports valid continuously after reset -> grants alternate p0, p1, p0, p1.
REQ-037 rst asserted in RDWAIT -> no rvalid; next cycle IDLE with all controls inactive.
REQ-038 Stats build, p0 accepted 3 times and p1 accepted 2 times -> p0_grant_cnt=3, p1_grant_cnt=2.
REQ-039 Throughout all scenarios, the bus-conflict checker required by REQ-026 SHALL never fire.
